// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-ported
// word memory. Port 0 (fetch) only reads; port 1 (data) reads or writes.
// Each access is IDLE -> ACCESS -> RESP, so a request granted at one edge is
// acknowledged in the cycle after the second edge that follows it.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   f_req, f_addr              fetch request (always a read) and word address
//   f_ack, f_rdata             fetch completion pulse and registered read data
//   d_req, d_we, d_addr,       data request, 1 = store / 0 = load,
//   d_wdata                    word address and store data
//   d_ack, d_rdata             data completion pulse and registered read data
//   mem_cmd                    2'b00 none, 2'b01 read, 2'b11 write
//   mem_addr, mem_wdata        memory address and write data
//   mem_rdata                  memory read data, valid the cycle after a read
//   busy                       high whenever the arbiter is not IDLE
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [8:0]  f_addr,
  output logic        f_ack,
  output logic [15:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [8:0]  d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic [1:0]  mem_cmd,
  output logic [8:0]  mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;

  // last_grant doubles as the "currently granted port" once an access starts,
  // since it is updated at the moment of grant.
  logic last_grant;
  logic cur_we;
  logic pick_data;

  // The data port wins when it is the only requester, or when both request
  // and the fetch port was served most recently.
  assign pick_data = d_req && (!f_req || !last_grant);

  assign busy = (state != IDLE);

  // mem_addr and mem_wdata double as the latched request registers, so later
  // changes on the request ports cannot disturb an access in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cur_we     <= 1'b0;
      mem_cmd    <= 2'b00;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      f_ack      <= 1'b0;
      d_ack      <= 1'b0;
      f_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          f_ack   <= 1'b0;
          d_ack   <= 1'b0;
          mem_cmd <= 2'b00;
          if (f_req || d_req) begin
            last_grant <= pick_data;
            if (pick_data) begin
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              cur_we    <= d_we;
              mem_cmd   <= d_we ? 2'b11 : 2'b01;
            end else begin
              mem_addr  <= f_addr;
              mem_wdata <= '0;
              cur_we    <= 1'b0;
              mem_cmd   <= 2'b01;
            end
            state <= ACCESS;
          end
        end

        ACCESS: begin
          mem_cmd <= 2'b00;
          state   <= RESP;
        end

        // Memory read data is valid during RESP; capture it into the granted
        // port only, and raise that port's ack for the following cycle.
        RESP: begin
          if (!cur_we) begin
            if (last_grant) begin
              d_rdata <= mem_rdata;
            end else begin
              f_rdata <= mem_rdata;
            end
          end
          f_ack <= !last_grant;
          d_ack <= last_grant;
          state <= IDLE;
        end

        default: begin
          mem_cmd <= 2'b00;
          f_ack   <= 1'b0;
          d_ack   <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized bench for mem_arbiter. A small
// behavioural memory answers the arbiter's commands; a transaction-level
// reference model predicts every output each cycle.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        f_req;
  logic [8:0]  f_addr;
  logic        f_ack;
  logic [15:0] f_rdata;
  logic        d_req;
  logic        d_we;
  logic [8:0]  d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  int checks_total  = 0;
  int checks_passed = 0;

  mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_ack     (f_ack),
    .f_rdata   (f_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-on contents of the memory; a few words carry known values.
  function automatic logic [15:0] initPattern(input logic [8:0] a);
    case (a)
      9'h005:  return 16'hD0A5;
      9'h010:  return 16'hBEEF;
      9'h020:  return 16'h2020;
      default: return {a[7:0] ^ 8'h5A, 7'h13, a[8]};
    endcase
  endfunction

  // Behavioural memory: words never written return their power-on pattern.
  logic [15:0] mem [512];
  bit   [511:0] written;

  always @(posedge clk) begin
    if (mem_cmd == 2'b11) begin
      mem[mem_addr]     <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end else if (mem_cmd == 2'b01) begin
      mem_rdata <= written[mem_addr] ? mem[mem_addr] : initPattern(mem_addr);
    end
  end

  // Reference model: age counts cycles since the grant (0 = nothing in flight,
  // 1 = command cycle, 2 = response wait, 3 = ack cycle).
  logic [15:0] ref_mem [512];
  int          age;
  bit          last_port;
  bit          tx_port;
  bit          tx_we;
  logic [8:0]  tx_addr;
  logic [15:0] tx_wdata;
  logic [15:0] tx_rdata;
  logic [15:0] exp_f_rdata;
  logic [15:0] exp_d_rdata;

  task automatic modelReset();
    age         = 0;
    last_port   = 1'b1;
    exp_f_rdata = '0;
    exp_d_rdata = '0;
  endtask

  // A new grant may happen when nothing is in flight or in the ack cycle.
  task automatic modelEdge();
    if (reset) begin
      modelReset();
    end else if (age == 0 || age == 3) begin
      if (f_req || d_req) begin
        tx_port   = (f_req && d_req) ? !last_port : d_req;
        last_port = tx_port;
        tx_we     = tx_port ? d_we : 1'b0;
        tx_addr   = tx_port ? d_addr : f_addr;
        tx_wdata  = d_wdata;
        if (tx_we) ref_mem[tx_addr] = tx_wdata;
        else       tx_rdata = ref_mem[tx_addr];
        age = 1;
      end else begin
        age = 0;
      end
    end else begin
      age = age + 1;
      if (age == 3 && !tx_we) begin
        if (tx_port) exp_d_rdata = tx_rdata;
        else         exp_f_rdata = tx_rdata;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
    checks_total++;
    assert (obs === expv) checks_passed++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".mem_cmd"}, 32'(mem_cmd),
                32'((age == 1) ? (tx_we ? 2'b11 : 2'b01) : 2'b00));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(age == 1 || age == 2));
    checkOutput({tag, ".f_ack"}, 32'(f_ack), 32'(age == 3 && !tx_port));
    checkOutput({tag, ".d_ack"}, 32'(d_ack), 32'(age == 3 && tx_port));
    checkOutput({tag, ".f_rdata"}, 32'(f_rdata), 32'(exp_f_rdata));
    checkOutput({tag, ".d_rdata"}, 32'(d_rdata), 32'(exp_d_rdata));
    if (age == 1 || age == 2)
      checkOutput({tag, ".mem_addr"}, 32'(mem_addr), 32'(tx_addr));
    if (age == 1 && tx_we)
      checkOutput({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(tx_wdata));
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".mem_cmd"}, 32'(mem_cmd), 32'd0);
    checkOutput({tag, ".mem_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, ".mem_wdata"}, 32'(mem_wdata), 32'd0);
    checkOutput({tag, ".f_ack"}, 32'(f_ack), 32'd0);
    checkOutput({tag, ".d_ack"}, 32'(d_ack), 32'd0);
    checkOutput({tag, ".f_rdata"}, 32'(f_rdata), 32'd0);
    checkOutput({tag, ".d_rdata"}, 32'(d_rdata), 32'd0);
    checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  task automatic applyStimulus(input logic fr, input logic [8:0] fa,
                               input logic dr, input logic dwe,
                               input logic [8:0] da, input logic [15:0] dw);
    f_req   = fr;
    f_addr  = fa;
    d_req   = dr;
    d_we    = dwe;
    d_addr  = da;
    d_wdata = dw;
  endtask

  // Inputs change on the falling edge; outputs are checked on the next one.
  task automatic stepCycle(input string tag);
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkAll(tag);
  endtask

  task automatic resetDut(input string tag);
    @(negedge clk);
    applyStimulus(0, 9'h0, 0, 0, 9'h0, 16'h0);
    reset = 1'b1;
    #1;
    modelReset();
    checkReset(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [8:0] pickAddr();
    case ($urandom_range(0, 9))
      0:       return 9'h000;
      1:       return 9'h1FF;
      default: return 9'($urandom_range(0, 15));
    endcase
  endfunction

  // Random requesters: hold req until ack, usually drop it in the ack cycle,
  // occasionally drop it early once granted; other fields churn every cycle.
  task automatic driveRandom();
    if (f_req && f_ack)  f_req = ($urandom_range(0, 3) == 0);
    else if (!f_req)     f_req = ($urandom_range(0, 1) == 0);
    else if ((age == 1 || age == 2) && !tx_port && $urandom_range(0, 7) == 0)
      f_req = 1'b0;
    if (d_req && d_ack)  d_req = ($urandom_range(0, 3) == 0);
    else if (!d_req)     d_req = ($urandom_range(0, 1) == 0);
    else if ((age == 1 || age == 2) && tx_port && $urandom_range(0, 7) == 0)
      d_req = 1'b0;
    f_addr  = pickAddr();
    d_addr  = pickAddr();
    d_we    = 1'($urandom_range(0, 1));
    d_wdata = 16'($urandom);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = initPattern(9'(i));
    modelReset();
    reset = 1'b0;
    applyStimulus(0, 9'h0, 0, 0, 9'h0, 16'h0);
    #1 reset = 1'b1;
    #2 checkReset("por");
    reset = 1'b0;
    resetDut("reset");

    $display("[TB] idle for 10 cycles");
    for (int i = 0; i < 10; i++) stepCycle("idle");

    $display("[TB] fetch read of word 5");
    applyStimulus(1, 9'h005, 0, 0, 9'h0, 16'h0);
    stepCycle("fetch");
    checkOutput("fetch.cmd_read", 32'(mem_cmd), 32'h1);
    stepCycle("fetch");
    stepCycle("fetch");
    checkOutput("fetch.ack", 32'(f_ack), 32'h1);
    checkOutput("fetch.data", 32'(f_rdata), 32'hD0A5);
    applyStimulus(0, 9'h005, 0, 0, 9'h0, 16'h0);
    stepCycle("fetch");

    $display("[TB] store then load at 0x1F0");
    applyStimulus(0, 9'h0, 1, 1, 9'h1F0, 16'h1234);
    stepCycle("store");
    checkOutput("store.cmd_write", 32'(mem_cmd), 32'h3);
    checkOutput("store.addr", 32'(mem_addr), 32'h1F0);
    stepCycle("store");
    stepCycle("store");
    checkOutput("store.ack", 32'(d_ack), 32'h1);
    applyStimulus(0, 9'h0, 1, 0, 9'h1F0, 16'h0);
    stepCycle("load");
    stepCycle("load");
    stepCycle("load");
    checkOutput("load.data", 32'(d_rdata), 32'h1234);
    applyStimulus(0, 9'h0, 0, 0, 9'h1F0, 16'h0);
    stepCycle("load");

    $display("[TB] contention after reset");
    resetDut("reset2");
    applyStimulus(1, 9'h030, 1, 0, 9'h031, 16'h0);
    for (int g = 0; g < 3; g++) begin
      stepCycle("contend");
      stepCycle("contend");
      stepCycle("contend");
      checkOutput("contend.f_ack", 32'(f_ack), 32'(g != 1));
      checkOutput("contend.d_ack", 32'(d_ack), 32'(g == 1));
    end
    applyStimulus(0, 9'h0, 0, 0, 9'h0, 16'h0);
    stepCycle("contend");

    $display("[TB] address change after grant");
    applyStimulus(0, 9'h0, 1, 0, 9'h010, 16'h0);
    stepCycle("addr_chg");
    d_addr = 9'h020;
    stepCycle("addr_chg");
    checkOutput("addr_chg.mem_addr", 32'(mem_addr), 32'h010);
    stepCycle("addr_chg");
    checkOutput("addr_chg.data", 32'(d_rdata), 32'hBEEF);
    applyStimulus(0, 9'h0, 0, 0, 9'h020, 16'h0);
    stepCycle("addr_chg");

    $display("[TB] reset during ACCESS");
    applyStimulus(1, 9'h007, 0, 0, 9'h0, 16'h0);
    stepCycle("mid_rst");
    #2 reset = 1'b1;
    f_req = 1'b0;
    #1;
    modelReset();
    checkReset("mid_rst.async");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) stepCycle("post_rst");
    applyStimulus(1, 9'h007, 0, 0, 9'h0, 16'h0);
    stepCycle("post_rst");
    stepCycle("post_rst");
    stepCycle("post_rst");
    checkOutput("post_rst.ack", 32'(f_ack), 32'h1);
    checkOutput("post_rst.data", 32'(f_rdata), 32'(initPattern(9'h007)));
    applyStimulus(0, 9'h0, 0, 0, 9'h0, 16'h0);
    stepCycle("post_rst");

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      driveRandom();
      stepCycle("rand");
    end
    applyStimulus(0, 9'h0, 0, 0, 9'h0, 16'h0);
    for (int i = 0; i < 4; i++) stepCycle("drain");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  in  1  sole clock; all state changes on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; forces reset state immediately, independent of clk.
REQ-003 f_req  in  1  fetch port (port 0) request, level.
REQ-004 f_addr  in  9  fetch port word address.
REQ-005 f_ack  out  1  fetch port completion pulse, one cycle.
REQ-006 f_rdata  out  16  fetch port read data, registered.
REQ-007 d_req  in  1  data port (port 1) request, level.
REQ-008 d_we  in  1  data port: 1 = store (write), 0 = load (read).
REQ-009 d_addr  in  9  data port word address.
REQ-010 d_wdata  in  16  data port store data.
REQ-011 d_ack  out  1  data port completion pulse, one cycle.
REQ-012 d_rdata  out  16  data port read data, registered.
REQ-013 mem_cmd  out  2  memory command: 2'b00 none, 2'b01 read, 2'b11 write.
REQ-014 mem_addr  out  9  memory address.
REQ-015 mem_wdata  out  16  memory write data.
REQ-016 mem_rdata  in  16  memory read data, valid the cycle after a read command.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ACCESS, RESP.
REQ-019 In IDLE with no request pending, the block SHALL remain in IDLE with mem_cmd = 2'b00.
REQ-020 In IDLE with any request pending, the block SHALL grant one port, latch that port's address, we and wdata into internal registers, and move to ACCESS.
REQ-021 Fetch requests SHALL be treated as reads (we = 0).
REQ-022 On simultaneous f_req and d_req, the grant SHALL go to the port not served most recently (round-robin); a last_grant bit SHALL record the most recently served port.
REQ-023 With a single requester, that port SHALL be granted regardless of last_grant.
REQ-024 ACCESS SHALL last exactly one cycle, driving mem_addr and mem_wdata from the latched registers and mem_cmd = 2'b11 for a store or 2'b01 for a read; the next state SHALL be RESP.
REQ-025 In RESP, mem_cmd SHALL be 2'b00 and mem_addr SHALL still hold the latched address.
REQ-026 In RESP, for a read, the block SHALL register mem_rdata into the granted port's rdata output, effective on the RESP clock edge.
REQ-027 The granted port's ack SHALL be high for exactly the one cycle following RESP, together with valid rdata; the next state SHALL be IDLE.
REQ-028 Latency SHALL be fixed: for a request sampled in IDLE at edge N, ack is high in the cycle after edge N+2.
REQ-029 Back-to-back throughput SHALL be one access per three cycles.
REQ-030 Requests sampled during ACCESS or RESP SHALL be ignored and re-arbitrated in IDLE.
REQ-031 A requester SHALL hold req until it sees ack and drop req in the ack cycle.
REQ-032 If req is still high in the cycle after ack, it SHALL be treated as a new request.
REQ-033 Changes to addr, we or wdata after grant SHALL NOT affect the access in progress.
REQ-034 Deassertion of req after grant SHALL NOT abort the access; ack SHALL still be issued.
REQ-035 The rdata outputs SHALL hold their value until the next read completion on that port.
REQ-036 A store SHALL NOT modify d_rdata.
REQ-037 An ack SHALL never be issued to the port that was not granted; f_ack and d_ack SHALL never be high in the same cycle.
REQ-038 Address width rule: the address passes through unmodified; no wrap or increment is performed by this block.

Reset
REQ-039 On reset assertion, regardless of clock or state, the block SHALL enter IDLE, aborting any access in progress without issuing ack.
REQ-040 Reset SHALL set: mem_cmd = 2'b00, mem_addr = 0, mem_wdata = 0, f_ack = d_ack = 0, f_rdata = d_rdata = 0, busy = 0.
REQ-041 Reset SHALL set last_grant = port 1, so port 0 wins the first contention.
REQ-042 After reset deasserts, the first rising edge SHALL arbitrate normally.

Verification
REQ-043 Fetch read: memory word 0x005 = 16'hD0A5; assert f_req, f_addr = 5 -> mem_cmd = 01 for one cycle, then f_ack for one cycle with f_rdata = 16'hD0A5.
REQ-044 Store then load: d_we = 1, d_addr = 0x1F0, d_wdata = 16'h1234 -> mem_cmd = 11 with mem_addr = 0x1F0 and d_ack; then d_we = 0 at the same address -> d_rdata = 16'h1234.
REQ-045 Contention after reset: f_req and d_req both held -> grants in order port 0, port 1, port 0, each ack three cycles apart.
REQ-046 Address change after grant: change d_addr from 0x010 to 0x020 in the ACCESS cycle -> mem_addr stays 0x010 and the correct data is returned.
REQ-047 Reset mid-access: assert reset during ACCESS -> outputs reach their reset values asynchronously, no ack is issued, and the next request completes normally.
REQ-048 Idle check: no requests for 10 cycles -> mem_cmd = 00, busy = 0, no ack.
